// File: rtl/router_pkg.sv
// Shared router constants: port count, address width and FSM state encoding.
// Also reused by the synchronizer and FIFO blocks.
package router_pkg;

    localparam int NUM_PORTS = 3;
    localparam int ADDR_W    = 2;

    typedef logic [2:0] state_t;

    localparam state_t DECODE_ADDRESS     = 3'd0;
    localparam state_t LOAD_FIRST_DATA    = 3'd1;
    localparam state_t LOAD_DATA          = 3'd2;
    localparam state_t FIFO_FULL_STATE    = 3'd3;
    localparam state_t LOAD_AFTER_FULL    = 3'd4;
    localparam state_t LOAD_PARITY        = 3'd5;
    localparam state_t CHECK_PARITY_ERROR = 3'd6;
    localparam state_t WAIT_TILL_EMPTY    = 3'd7;

    // Selects the per-port flag for a port address; address 3 selects nothing.
    function automatic logic port_sel(
        input logic [NUM_PORTS-1:0] vec,
        input logic [ADDR_W-1:0]    idx
    );
        logic r;
        r = 1'b0;
        case (idx)
            2'd0:    r = vec[0];
            2'd1:    r = vec[1];
            2'd2:    r = vec[2];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Router control FSM: decodes the header address, sequences header/payload/
// parity loading into the selected FIFO and stalls the source while full.
module router_fsm
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] din,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    input  logic              fifo_full,
    input  logic              empty_0,
    input  logic              empty_1,
    input  logic              empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    output logic              detect_addr,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              wr_en_reg,
    output logic              rst_int_reg,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [NUM_PORTS-1:0] empty_vec;
    logic [NUM_PORTS-1:0] sreset_vec;
    logic                 empty_addr;
    logic                 sreset_addr;

    assign empty_vec   = {empty_2, empty_1, empty_0};
    assign sreset_vec  = {soft_reset_2, soft_reset_1, soft_reset_0};
    assign empty_addr  = port_sel(empty_vec, addr_q);
    assign sreset_addr = port_sel(sreset_vec, addr_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        detect_addr = 1'b0;
        lfd_state   = 1'b0;
        ld_state    = 1'b0;
        laf_state   = 1'b0;
        full_state  = 1'b0;
        wr_en_reg   = 1'b0;
        rst_int_reg = 1'b0;
        busy        = 1'b1;

        unique case (state_q)
            DECODE_ADDRESS: begin
                detect_addr = 1'b1;
                busy        = 1'b0;
                if (pkt_valid && din != 2'd3) begin
                    addr_d  = din;
                    state_d = port_sel(empty_vec, din) ? LOAD_FIRST_DATA
                                                       : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (empty_addr)
                    state_d = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: begin
                lfd_state = 1'b1;
                state_d   = LOAD_DATA;
            end
            LOAD_DATA: begin
                ld_state  = 1'b1;
                wr_en_reg = 1'b1;
                busy      = 1'b0;
                if (fifo_full)
                    state_d = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                if (!fifo_full)
                    state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                laf_state = 1'b1;
                wr_en_reg = 1'b1;
                if (parity_done)
                    state_d = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    state_d = LOAD_PARITY;
                else
                    state_d = LOAD_DATA;
            end
            LOAD_PARITY: begin
                wr_en_reg = 1'b1;
                state_d   = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                state_d     = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: begin
                state_d = DECODE_ADDRESS;
            end
        endcase

        // A timeout on the selected FIFO abandons the packet from any state.
        if (state_q != DECODE_ADDRESS && sreset_addr)
            state_d = DECODE_ADDRESS;
    end

endmodule

// File: doc/router_fsm.md
ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 No parameters; port count fixed at 3, address field 2 bits.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 pkt_valid  input  1  packet byte on din is valid; deasserts on the parity byte.
REQ-005 din  input  2  address bits of header byte; meaningful only in DECODE_ADDRESS.
REQ-006 parity_done  input  1  parity byte has been latched by the register stage.
REQ-007 low_pkt_valid  input  1  register stage saw pkt_valid fall while FIFO was full.
REQ-008 fifo_full  input  1  selected FIFO is full (from synchronizer).
REQ-009 empty_0/empty_1/empty_2  input  1 each  FIFO n is empty.
REQ-010 soft_reset_0/soft_reset_1/soft_reset_2  input  1 each  FIFO n timed out (from synchronizer).
REQ-011 detect_addr  output  1  header byte is being decoded.
REQ-012 lfd_state  output  1  loading header (first) byte.
REQ-013 ld_state  output  1  loading payload bytes.
REQ-014 laf_state  output  1  loading byte held during full.
REQ-015 full_state  output  1  stalled on full FIFO.
REQ-016 wr_en_reg  output  1  register stage may write FIFO.
REQ-017 rst_int_reg  output  1  register stage clears internal parity/hold state.
REQ-018 busy  output  1  source must hold current byte.

Function
REQ-019 States SHALL be DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY; one transition per clk.
REQ-020 A 2-bit addr register SHALL capture din when state=DECODE_ADDRESS and pkt_valid=1 and din!=3; it holds otherwise.
REQ-021 DECODE_ADDRESS: pkt_valid, din=n (n<3), empty_n=1 -> LOAD_FIRST_DATA; pkt_valid, din=n, empty_n=0 -> WAIT_TILL_EMPTY; din=3 or pkt_valid=0 -> stay.
REQ-022 WAIT_TILL_EMPTY: empty_addr=1 -> LOAD_FIRST_DATA; else stay.
REQ-023 LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
REQ-024 LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else pkt_valid=0 -> LOAD_PARITY; else stay.
REQ-025 FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
REQ-026 LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
REQ-027 LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
REQ-028 CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
REQ-029 soft_reset_addr=1 in any state except DECODE_ADDRESS SHALL force next state DECODE_ADDRESS, overriding REQ-022..028; soft resets of non-selected ports are ignored.
REQ-030 Outputs SHALL be Moore, decoded from current state only: detect_addr=DECODE_ADDRESS; lfd_state=LOAD_FIRST_DATA; ld_state=LOAD_DATA; laf_state=LOAD_AFTER_FULL; full_state=FIFO_FULL_STATE; rst_int_reg=CHECK_PARITY_ERROR.
REQ-031 wr_en_reg SHALL be 1 in LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY; busy SHALL be 1 in all states except DECODE_ADDRESS and LOAD_DATA.
REQ-032 Outputs SHALL be mutually consistent: exactly one of detect_addr/lfd_state/ld_state/laf_state/full_state/rst_int_reg or none (LOAD_PARITY, WAIT_TILL_EMPTY) is 1.

Reset
REQ-033 rst=1 SHALL immediately set state=DECODE_ADDRESS, addr=0: detect_addr=1, all other outputs 0.
REQ-034 rst mid-packet SHALL abandon the packet; first edge after release evaluates DECODE_ADDRESS.

Structure
REQ-035 State encoding (3-bit localparams) and port-count/address-width constants SHALL live in shared package router_pkg, reused by synchronizer and FIFO.
REQ-036 No sub-module; single two-process FSM (state register + next-state/output logic).

Verification
REQ-037 Reset, then pkt_valid=1, din=1, empty_1=1 -> LOAD_FIRST_DATA next cycle (lfd_state=1, busy=1), then LOAD_DATA (wr_en_reg=1, busy=0).
REQ-038 din=2, empty_2=0 for 4 cycles then 1 -> WAIT_TILL_EMPTY, busy=1 for 4 cycles, then lfd_state=1.
REQ-039 In LOAD_DATA drop pkt_valid -> LOAD_PARITY (wr_en_reg=1, busy=1) -> CHECK_PARITY_ERROR (rst_int_reg=1) -> detect_addr=1.
REQ-040 fifo_full=1 in LOAD_DATA for 3 cycles -> full_state=1 x3, then laf_state=1; with parity_done=1 -> DECODE_ADDRESS; with low_pkt_valid=1 -> LOAD_PARITY.
REQ-041 addr=0 in WAIT_TILL_EMPTY, pulse soft_reset_1 -> no change; pulse soft_reset_0 -> detect_addr=1 next cycle.
REQ-042 din=3 with pkt_valid=1 -> remains DECODE_ADDRESS, addr unchanged; rst asserted in FIFO_FULL_STATE -> detect_addr=1 before next edge.
